rf_access_arbiter: RTL and testbench
====================================

# rf_access_arbiter

Shares the single-ported register file between up to `N_REQ` requesters (decoder source-operand reads, ALU writeback, load/debug access). It accepts per-requester read/write requests, grants one per cycle under round-robin with optional write priority, and drives the register-file control and address lines from registers. It returns read data to the originating requester with a fixed two-cycle latency and handles `x0` locally.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters, 2..8.
- `WR_FIRST`, 1: when 1, any pending write beats every pending read. When 0, pure round-robin.

Ports:
- `clk` in 1: the single clock. All logic is on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req` in `N_REQ`: request valid per requester. Held until its `gnt` bit is seen.
- `req_we` in `N_REQ`: 1 selects write, 0 selects read.
- `req_addr` in `N_REQ*5`: register address, requester i at `[5i+4:5i]`.
- `req_wdata` in `N_REQ*32`: write data, requester i at `[32i+31:32i]`.
- `gnt` out `N_REQ`: combinational one-hot grant, valid in the request cycle.
- `rsp_valid` out `N_REQ`: one-hot read-data-valid pulse.
- `rsp_data` out 32: read data, shared by all requesters and qualified by `rsp_valid`.
- `RF_chip_enable` out 1: register-file access strobe (registered).
- `RF_write_enable` out 1: 1 = write, 0 = read (registered).
- `RF_rs1_address` out 5: read address (registered).
- `RF_WR_add` out 5: write address (registered).
- `RF_WriteData` out 32: write data (registered).
- `RF_reg1_data` in 32: RF read data, valid in the cycle after a read strobe.

## Operation
- Arbitration:
  - Each cycle, the candidate set is the `req` bits.
  - If `WR_FIRST` is set and any requester with `req_we=1` is pending, the candidate set is reduced to the pending writes.
  - The winner is the first candidate at or after `rr_ptr`, wrapping modulo `N_REQ`.
- `gnt[winner]=1` for that one cycle.
- `rr_ptr` then becomes (winner+1) mod `N_REQ`. It is unchanged when there is no grant.
- Issue register: on a grant, the next cycle drives the RF port from registers.
  - `RF_chip_enable=1`.
  - `RF_write_enable=req_we[winner]`.
  - Addresses and data are taken from the winner.
  - With no grant, `RF_chip_enable=0` and `RF_write_enable=0`; addresses and data hold their previous values.
- x0 write: granted normally, but `RF_chip_enable` and `RF_write_enable` stay 0. The register file is never written.
- x0 read: granted. `RF_chip_enable` stays 0 and `rsp_data=0` with `rsp_valid` on the usual cycle.
- Response pipeline:
  - A 2-stage tracker holds {valid, requester id, is_x0} for every granted read.
  - Stage 2 asserts `rsp_valid[id]`.
  - `rsp_data` is `RF_reg1_data`, or 0 for x0.
- Writes produce no response. `gnt` is the completion indication.
- Throughput: one access per cycle, with back-to-back grants to different or the same requester.
- Reset values:
  - `gnt=0`, `rsp_valid=0`, `rsp_data=0`.
  - All `RF_*` outputs = 0.
  - `rr_ptr=0`, tracker empty.
- Reset mid-operation: in-flight reads are discarded, no `rsp_valid` follows, and a requester must re-request. A request present during `rst` is not granted.

## Timing
- Cycle t: `req[i]` high, `gnt[i]` high in t (combinational from `req`, `req_we` and `rr_ptr`).
- Cycle t+1: RF strobe/address/data driven.
- Cycle t+2: `RF_reg1_data` valid; `rsp_valid[i]` and `rsp_data` asserted. Read latency is therefore 2 cycles from grant.
- A requester deasserts `req`, or presents the next request, in t+1. If `req` is still high in t+1 it is a new request.
- Simultaneous write by requester A and read of the same address by requester B in cycle t (`WR_FIRST=1`): the write is granted at t and the read at t+1. The read returns the new value, with no forwarding logic needed.
- No combinational path from `RF_reg1_data` to anything other than `rsp_data`.

## Structure
- Package `rf_arb_pkg`:
  - `RF_ADDR_W=5`, `RF_DATA_W=32`, `REG_X0=5'd0`.
  - Response-tracker struct {valid, id, is_x0}.
- Sub-module `rr_picker`: combinational rotate-priority one-hot selector, with inputs candidate mask and `rr_ptr`, and output one-hot winner. It is used once.

## Test plan
- Single read: `req[0]` read addr 5, RF returns 0xDEADBEEF → `gnt[0]` at t, `RF_chip_enable=1`/`RF_rs1_address=5` at t+1, `rsp_valid[0]` with 0xDEADBEEF at t+2.
- Round-robin: all three request reads continuously with `WR_FIRST=0` → grants 0,1,2,0,1,2 on consecutive cycles, no gaps.
- Write priority: `req[0]` read, `req[2]` write addr 7 data 0x1234 in the same cycle with `WR_FIRST=1` → `gnt[2]` first with `RF_write_enable=1`, `RF_WR_add=7`; `gnt[0]` next cycle.
- x0: write 0xFFFF to x0 → granted, `RF_chip_enable` stays 0. Read x0 → `rsp_data=0` at t+2, `RF_chip_enable` stays 0.
- Reset mid-read: grant read at t, `rst` high at t+1 → no `rsp_valid` at t+2, all outputs 0, next grant goes to requester 0.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared widths, x0 constant and response-tracker entry for the register-file arbiter.
// Pure declarations; no timing or flow control of its own.
package rf_arb_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int ID_W = 3;
  localparam logic [RF_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            is_x0;
  } rsp_trk_t;
endpackage

// File: rtl/rr_picker.sv
// Rotate-priority one-hot selector: first candidate at or after rr_ptr, wrapping.
// Purely combinational; a zero candidate mask yields a zero winner.
module rr_picker #(
  parameter int N_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] cand,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] win
);
  logic found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    // Upper segment (at or after the pointer) first, then the wrapped lower segment.
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && cand[i] && (PTR_W'(i) >= rr_ptr)) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && cand[i] && (PTR_W'(i) < rr_ptr)) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter sharing one single-ported register file; x0 handled locally.
// Grant is same-cycle, RF strobe one cycle later, read data two cycles after grant; losers hold req.
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter bit WR_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*RF_ADDR_W-1:0] req_addr,
  input  logic [N_REQ*RF_DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [RF_DATA_W-1:0]       rsp_data,
  output logic                       RF_chip_enable,
  output logic                       RF_write_enable,
  output logic [RF_ADDR_W-1:0]       RF_rs1_address,
  output logic [RF_ADDR_W-1:0]       RF_WR_add,
  output logic [RF_DATA_W-1:0]       RF_WriteData,
  input  logic [RF_DATA_W-1:0]       RF_reg1_data
);
  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     win_idx;
  logic [N_REQ-1:0]     wr_pend;
  logic [N_REQ-1:0]     cand;
  logic [N_REQ-1:0]     win;
  logic                 win_we;
  logic [RF_ADDR_W-1:0] win_addr;
  logic [RF_DATA_W-1:0] win_wdata;
  logic                 any_gnt;
  logic                 win_x0;
  rsp_trk_t             trk1;
  rsp_trk_t             trk2;

  assign wr_pend = req & req_we;
  assign cand    = (WR_FIRST && (|wr_pend)) ? wr_pend : req;

  rr_picker #(
    .N_REQ(N_REQ),
    .PTR_W(PTR_W)
  ) u_picker (
    .cand  (cand),
    .rr_ptr(rr_ptr),
    .win   (win)
  );

  // A request seen while reset is asserted must not be granted.
  assign gnt     = rst ? '0 : win;
  assign any_gnt = |gnt;

  always_comb begin
    win_idx   = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        win_idx   = PTR_W'(i);
        win_we    = req_we[i];
        win_addr  = req_addr[i*RF_ADDR_W +: RF_ADDR_W];
        win_wdata = req_wdata[i*RF_DATA_W +: RF_DATA_W];
      end
    end
  end

  assign win_x0 = (win_addr == REG_X0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr          <= '0;
      RF_chip_enable  <= 1'b0;
      RF_write_enable <= 1'b0;
      RF_rs1_address  <= '0;
      RF_WR_add       <= '0;
      RF_WriteData    <= '0;
      trk1            <= '0;
      trk2            <= '0;
    end else begin
      // x0 accesses are granted but never reach the register file.
      RF_chip_enable  <= any_gnt && !win_x0;
      RF_write_enable <= any_gnt && win_we && !win_x0;
      if (any_gnt) begin
        rr_ptr         <= (win_idx == PTR_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
        RF_rs1_address <= win_addr;
        RF_WR_add      <= win_addr;
        RF_WriteData   <= win_wdata;
      end
      trk1.valid <= any_gnt && !win_we;
      trk1.id    <= ID_W'(win_idx);
      trk1.is_x0 <= win_x0;
      trk2       <= trk1;
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = trk2.valid && (trk2.id == ID_W'(i));
    end
    rsp_data = (trk2.valid && !trk2.is_x0) ? RF_reg1_data : '0;
  end
endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter (N_REQ=3, WR_FIRST=1) with a behavioural register file.
// Directed scenarios plus a randomized run scored against a request-level model.
module tb_rf_access_arbiter;
  localparam int N = 3;
  localparam bit WR_FIRST = 1'b1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*5-1:0]  req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_data;
  logic            RF_chip_enable;
  logic            RF_write_enable;
  logic [4:0]      RF_rs1_address;
  logic [4:0]      RF_WR_add;
  logic [31:0]     RF_WriteData;
  logic [31:0]     RF_reg1_data;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rf_access_arbiter #(.N_REQ(N), .WR_FIRST(WR_FIRST)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .gnt            (gnt),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .RF_chip_enable (RF_chip_enable),
    .RF_write_enable(RF_write_enable),
    .RF_rs1_address (RF_rs1_address),
    .RF_WR_add      (RF_WR_add),
    .RF_WriteData   (RF_WriteData),
    .RF_reg1_data   (RF_reg1_data)
  );

  function automatic logic [31:0] init_val(int a);
    if (a == 5) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(a) * 32'h0001_0101;
  endfunction

  // Behavioural single-ported register file, reloaded on every reset.
  logic [31:0] rf_mem [32];
  logic [31:0] rf_rd;
  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 32; a++) rf_mem[a] <= init_val(a);
      rf_rd <= 32'hBAD0BAD0;
    end else if (RF_chip_enable) begin
      if (RF_write_enable) rf_mem[RF_WR_add] <= RF_WriteData;
      else                 rf_rd <= rf_mem[RF_rs1_address];
    end
  end
  assign RF_reg1_data = rf_rd;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, bit we, logic [4:0] a, logic [31:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[5*i +: 5] = a;
    req_wdata[32*i +: 32] = d;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_req(0, 1'b0, 5'd5, 32'h0);
    set_req(2, 1'b1, 5'd7, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (gnt !== 3'b000) $display("FAIL reset_gnt got %b want 000", gnt); else n_pass++;
    n_chk++; if (rsp_valid !== 3'b000) $display("FAIL reset_rsp_valid got %b want 000", rsp_valid); else n_pass++;
    n_chk++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data got %h want 0", rsp_data); else n_pass++;
    n_chk++;
    if ({RF_chip_enable, RF_write_enable, RF_rs1_address, RF_WR_add, RF_WriteData} !== 44'h0)
      $display("FAIL reset_rf got ce=%b we=%b rs1=%0d wa=%0d wd=%h want all 0",
               RF_chip_enable, RF_write_enable, RF_rs1_address, RF_WR_add, RF_WriteData);
    else n_pass++;
    tick;
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_single_read;
    do_reset;
    set_req(0, 1'b0, 5'd5, 32'h0);
    @(negedge clk);
    n_chk++; if (gnt !== 3'b001) $display("FAIL single_gnt got %b want 001", gnt); else n_pass++;
    tick;
    req = '0;
    @(negedge clk);
    n_chk++;
    if (RF_chip_enable !== 1'b1 || RF_write_enable !== 1'b0 || RF_rs1_address !== 5'd5)
      $display("FAIL single_rf got ce=%b we=%b rs1=%0d want ce=1 we=0 rs1=5",
               RF_chip_enable, RF_write_enable, RF_rs1_address);
    else n_pass++;
    tick;
    @(negedge clk);
    n_chk++; if (rsp_valid !== 3'b001) $display("FAIL single_rsp_valid got %b want 001", rsp_valid); else n_pass++;
    n_chk++; if (rsp_data !== 32'hDEADBEEF) $display("FAIL single_rsp_data got %h want deadbeef", rsp_data); else n_pass++;
    tick;
    @(negedge clk);
    n_chk++; if (rsp_valid !== 3'b000) $display("FAIL single_rsp_pulse got %b want 000", rsp_valid); else n_pass++;
    tick;
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp_g;
    logic [N-1:0] exp_v;
    do_reset;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 5'(i + 1), 32'h0);
    for (int k = 0; k < 8; k++) begin
      if (k == 6) req = '0;
      @(negedge clk);
      exp_g = (k < 6) ? N'(1 << (k % N)) : '0;
      n_chk++; if (gnt !== exp_g) $display("FAIL rr_gnt cyc%0d got %b want %b", k, gnt, exp_g); else n_pass++;
      if (k >= 2) begin
        exp_v = N'(1 << ((k - 2) % N));
        n_chk++;
        if (rsp_valid !== exp_v || rsp_data !== init_val((k - 2) % N + 1))
          $display("FAIL rr_rsp cyc%0d got v=%b d=%h want v=%b d=%h",
                   k, rsp_valid, rsp_data, exp_v, init_val((k - 2) % N + 1));
        else n_pass++;
      end
      tick;
    end
  endtask

  task automatic test_write_priority;
    do_reset;
    set_req(0, 1'b0, 5'd7, 32'h0);
    set_req(2, 1'b1, 5'd7, 32'h1234);
    @(negedge clk);
    n_chk++; if (gnt !== 3'b100) $display("FAIL wp_gnt_first got %b want 100", gnt); else n_pass++;
    tick;
    req[2] = 1'b0;
    @(negedge clk);
    n_chk++; if (gnt !== 3'b001) $display("FAIL wp_gnt_second got %b want 001", gnt); else n_pass++;
    n_chk++;
    if (RF_chip_enable !== 1'b1 || RF_write_enable !== 1'b1 || RF_WR_add !== 5'd7 || RF_WriteData !== 32'h1234)
      $display("FAIL wp_rf_write got ce=%b we=%b wa=%0d wd=%h want 1 1 7 1234",
               RF_chip_enable, RF_write_enable, RF_WR_add, RF_WriteData);
    else n_pass++;
    tick;
    req = '0;
    @(negedge clk);
    n_chk++;
    if (RF_chip_enable !== 1'b1 || RF_write_enable !== 1'b0 || RF_rs1_address !== 5'd7)
      $display("FAIL wp_rf_read got ce=%b we=%b rs1=%0d want 1 0 7",
               RF_chip_enable, RF_write_enable, RF_rs1_address);
    else n_pass++;
    tick;
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 3'b001 || rsp_data !== 32'h1234)
      $display("FAIL wp_rsp got v=%b d=%h want 001 1234", rsp_valid, rsp_data);
    else n_pass++;
    tick;
  endtask

  task automatic test_x0;
    do_reset;
    set_req(1, 1'b1, 5'd0, 32'hFFFF);
    @(negedge clk);
    n_chk++; if (gnt !== 3'b010) $display("FAIL x0w_gnt got %b want 010", gnt); else n_pass++;
    tick;
    set_req(1, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    n_chk++;
    if (RF_chip_enable !== 1'b0 || RF_write_enable !== 1'b0)
      $display("FAIL x0w_rf got ce=%b we=%b want 0 0", RF_chip_enable, RF_write_enable);
    else n_pass++;
    n_chk++; if (gnt !== 3'b010) $display("FAIL x0r_gnt got %b want 010", gnt); else n_pass++;
    tick;
    req = '0;
    @(negedge clk);
    n_chk++; if (RF_chip_enable !== 1'b0) $display("FAIL x0r_rf got ce=%b want 0", RF_chip_enable); else n_pass++;
    tick;
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 3'b010 || rsp_data !== 32'h0)
      $display("FAIL x0r_rsp got v=%b d=%h want 010 0", rsp_valid, rsp_data);
    else n_pass++;
    tick;
  endtask

  task automatic test_reset_mid_read;
    do_reset;
    set_req(1, 1'b0, 5'd3, 32'h0);
    @(negedge clk);
    n_chk++; if (gnt !== 3'b010) $display("FAIL rmr_gnt got %b want 010", gnt); else n_pass++;
    tick;
    rst = 1'b1;
    req = '0;
    set_req(0, 1'b0, 5'd4, 32'h0);
    @(negedge clk);
    n_chk++; if (gnt !== 3'b000) $display("FAIL rmr_gnt_in_rst got %b want 000", gnt); else n_pass++;
    tick;
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 5'(i + 1), 32'h0);
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 3'b000 || rsp_data !== 32'h0)
      $display("FAIL rmr_rsp got v=%b d=%h want 000 0", rsp_valid, rsp_data);
    else n_pass++;
    n_chk++;
    if ({RF_chip_enable, RF_write_enable, RF_rs1_address, RF_WR_add, RF_WriteData} !== 44'h0)
      $display("FAIL rmr_rf got ce=%b we=%b rs1=%0d want all 0", RF_chip_enable, RF_write_enable, RF_rs1_address);
    else n_pass++;
    n_chk++; if (gnt !== 3'b001) $display("FAIL rmr_next_gnt got %b want 001", gnt); else n_pass++;
    tick;
    req = '0;
    repeat (3) tick;
  endtask

  task automatic test_random;
    logic [31:0]  mdl_mem [32];
    int           ptr;
    int           w;
    int           last_w;
    bit           any_wr;
    logic [4:0]   a;
    logic [N-1:0] exp_g;
    logic         m_ce, m_we;
    logic [4:0]   m_rs1, m_wra;
    logic [31:0]  m_wd, m_rd, p1_rd;
    logic [N-1:0] m_rv, p1_rv;
    do_reset;
    for (int i = 0; i < 32; i++) mdl_mem[i] = init_val(i);
    ptr = 0; last_w = -1;
    m_ce = 0; m_we = 0; m_rs1 = '0; m_wra = '0; m_wd = '0;
    m_rv = '0; m_rd = '0; p1_rv = '0; p1_rd = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (last_w >= 0) req[last_w] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && ($urandom_range(0, 1) == 1)) begin
          a = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          set_req(i, 1'($urandom_range(0, 1)), a, $urandom);
        end
      end
      any_wr = |(req & req_we);
      w = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ptr + k) % N;
        if (w < 0 && req[i] && (!(WR_FIRST && any_wr) || req_we[i])) w = i;
      end
      exp_g = (w < 0) ? '0 : N'(1 << w);
      @(negedge clk);
      n_chk++; if (gnt !== exp_g) $display("FAIL rnd_gnt cyc%0d got %b want %b", cyc, gnt, exp_g); else n_pass++;
      n_chk++;
      if ({RF_chip_enable, RF_write_enable, RF_rs1_address, RF_WR_add, RF_WriteData} !== {m_ce, m_we, m_rs1, m_wra, m_wd})
        $display("FAIL rnd_rf cyc%0d got ce=%b we=%b rs1=%0d wa=%0d wd=%h want ce=%b we=%b rs1=%0d wa=%0d wd=%h",
                 cyc, RF_chip_enable, RF_write_enable, RF_rs1_address, RF_WR_add, RF_WriteData,
                 m_ce, m_we, m_rs1, m_wra, m_wd);
      else n_pass++;
      n_chk++;
      if (rsp_valid !== m_rv || rsp_data !== m_rd)
        $display("FAIL rnd_rsp cyc%0d got v=%b d=%h want v=%b d=%h", cyc, rsp_valid, rsp_data, m_rv, m_rd);
      else n_pass++;
      m_rv = p1_rv;
      m_rd = p1_rd;
      p1_rv = '0;
      p1_rd = '0;
      if (w >= 0) begin
        a = req_addr[5*w +: 5];
        m_ce = (a != 5'd0);
        m_we = req_we[w] && (a != 5'd0);
        m_rs1 = a;
        m_wra = a;
        m_wd = req_wdata[32*w +: 32];
        if (req_we[w]) begin
          if (a != 5'd0) mdl_mem[a] = req_wdata[32*w +: 32];
        end else begin
          p1_rv = N'(1 << w);
          p1_rd = (a == 5'd0) ? 32'h0 : mdl_mem[a];
        end
        ptr = (w + 1) % N;
      end else begin
        m_ce = 0;
        m_we = 0;
      end
      last_w = w;
      tick;
    end
    req = '0;
  endtask

  initial begin
    #1;
    test_reset;
    test_single_read;
    test_round_robin;
    test_write_priority;
    test_x0;
    test_reset_mid_read;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
